// File: rtl/full_add_sub_pkg.sv
// full_add_sub_pkg: mode constants shared by the add/sub cell and the top
package full_add_sub_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/full_add_sub_if.sv
// full_add_sub_if: operand bus (A,B,C carry/borrow-in,D mode) and registered results (O1 sum/diff, O2 carry/borrow-out)
interface full_add_sub_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C;
  logic             D;
  logic [WIDTH-1:0] O1;
  logic             O2;
  modport master(output A, B, C, D, input O1, O2);
  modport slave(input A, B, C, D, output O1, O2);
endinterface

// File: rtl/full_add_sub_cell.sv
// full_add_sub_cell: 1-bit add/sub cell; a,b operands, ci carry/borrow-in, mode 0=add 1=sub, s result bit, co carry/borrow-out
module full_add_sub_cell
  import full_add_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  input  logic mode,
  output logic s,
  output logic co
);
  logic ax;
  always_comb begin
    ax = (mode == MODE_SUB) ? ~a : a;
    s  = a ^ b ^ ci;
    co = (ax & b) | (ax & ci) | (b & ci);
  end
endmodule

// File: rtl/full_add_sub.sv
// full_add_sub: WIDTH-bit ripple add/sub with registered O1/O2; clk, async active-low rst_n, bus slave carries A,B,C,D in and O1,O2 out
module full_add_sub
  import full_add_sub_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  full_add_sub_if.slave bus
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  assign c[0] = bus.C;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_add_sub_cell u_cell (
      .a   (bus.A[i]),
      .b   (bus.B[i]),
      .ci  (c[i]),
      .mode(bus.D),
      .s   (s[i]),
      .co  (c[i+1])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.O1 <= '0;
      bus.O2 <= 1'b0;
    end else begin
      bus.O1 <= s;
      bus.O2 <= c[WIDTH];
    end
  end
endmodule

// File: tb/tb_full_add_sub.sv
// tb_full_add_sub: scoreboard bench for WIDTH=1 and WIDTH=8 instances of full_add_sub
module tb_full_add_sub;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] q1[$];
  logic [8:0] q8[$];
  logic [1:0] add_tab[8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  logic [1:0] sub_tab[8] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 2'b11};
  full_add_sub_if #(.WIDTH(1)) if1 ();
  full_add_sub_if #(.WIDTH(8)) if8 ();
  full_add_sub #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  full_add_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [8:0] model(input int w, input logic [7:0] a, input logic [7:0] b, input logic c, input logic d);
    int m, ai, bi, r;
    logic o2;
    m  = 1 << w;
    ai = int'(a) & (m - 1);
    bi = int'(b) & (m - 1);
    r  = d ? ai - bi - int'(c) : ai + bi + int'(c);
    o2 = d ? (bi + int'(c) > ai) : (r >= m);
    return {o2, 8'(r & (m - 1))};
  endfunction
  task automatic step(input logic a1, input logic b1, input logic [7:0] a8, input logic [7:0] b8,
                      input logic c, input logic d, input logic [1:0] e1, input logic [8:0] e8);
    @(negedge clk);
    if1.A = a1; if1.B = b1; if1.C = c; if1.D = d;
    if8.A = a8; if8.B = b8; if8.C = c; if8.D = d;
    q1.push_back(e1);
    q8.push_back(e8);
  endtask
  task automatic chk_zero(input string name);
    checks++;
    if (if1.O1 !== 1'b0 || if1.O2 !== 1'b0 || if8.O1 !== 8'h00 || if8.O2 !== 1'b0) begin
      errors++;
      $display("FAIL %s: w1 O2,O1=%b%b w8 O2,O1=%b,%h required all zero", name, if1.O2, if1.O1, if8.O2, if8.O1);
    end
  endtask
  always @(posedge clk) begin
    logic [1:0] e1;
    logic [8:0] e8;
    #1;
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      checks++;
      if ({if1.O2, if1.O1} !== e1) begin
        errors++;
        $display("FAIL w1_out: got O2,O1=%b%b required %b%b", if1.O2, if1.O1, e1[1], e1[0]);
      end
    end
    if (q8.size() > 0) begin
      e8 = q8.pop_front();
      checks++;
      if ({if8.O2, if8.O1} !== e8) begin
        errors++;
        $display("FAIL w8_out: got O2=%b O1=%h required O2=%b O1=%h", if8.O2, if8.O1, e8[8], e8[7:0]);
      end
    end
  end
  initial begin
    logic [7:0] ra, rb;
    logic       rc, rd;
    logic [8:0] m1;
    rst_n = 1'b0;
    if1.A = 1'b1; if1.B = 1'b1; if1.C = 1'b1; if1.D = 1'b0;
    if8.A = 8'h01; if8.B = 8'h01; if8.C = 1'b1; if8.D = 1'b0;
    #3;
    chk_zero("reset_no_edge");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (if1.O1 !== 1'b1 || if1.O2 !== 1'b1 || if8.O1 !== 8'h03 || if8.O2 !== 1'b0) begin
      errors++;
      $display("FAIL release_first_edge: w1 O2,O1=%b%b w8 O2,O1=%b,%h required 11 and 0,03", if1.O2, if1.O1, if8.O2, if8.O1);
    end
    for (int i = 0; i < 8; i++)
      step(i[0], i[1], {7'd0, i[0]}, {7'd0, i[1]}, i[2], 1'b0, add_tab[i], model(8, {7'd0, i[0]}, {7'd0, i[1]}, i[2], 1'b0));
    for (int i = 0; i < 8; i++)
      step(i[0], i[1], {7'd0, i[0]}, {7'd0, i[1]}, i[2], 1'b1, sub_tab[i], 9'(i == 0 ? 9'h000 : i == 1 ? 9'h001 : i == 2 ? 9'h1FF :
           i == 3 ? 9'h000 : i == 4 ? 9'h1FF : i == 5 ? 9'h000 : i == 6 ? 9'h1FE : 9'h1FF));
    step(1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 2'b01, 9'h001);
    step(1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1, 2'b11, 9'h1FF);
    step(1'b0, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 2'b00, 9'h100);
    step(1'b1, 1'b1, 8'h05, 8'h07, 1'b1, 1'b1, 2'b11, 9'h1FD);
    step(1'b1, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1, 2'b01, 9'h001);
    @(posedge clk);
    #2;
    if1.A = 'x; if1.B = 'x; if1.C = 1'bx;
    if8.A = 'x; if8.B = 'x; if8.C = 1'bx;
    rst_n = 1'b0;
    #1;
    chk_zero("midstream_reset");
    @(posedge clk);
    #1;
    chk_zero("reset_x_inputs");
    @(negedge clk);
    if1.A = '0; if1.B = '0; if1.C = 1'b0; if1.D = 1'b0;
    if8.A = '0; if8.B = '0; if8.C = 1'b0; if8.D = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rd = 1'($urandom);
      m1 = model(1, ra, rb, rc, rd);
      step(ra[0], rb[0], ra, rb, rc, rd, {m1[8], m1[0]}, model(8, ra, rb, rc, rd));
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q1.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL drain: pending w1=%0d w8=%0d required 0", q1.size(), q8.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
